alu_mul_seq: RTL
================

# alu_mul_seq

Sequential 32×32 unsigned shift-add multiplier that time-shares the existing combinational `alu` as its only adder. It produces a 64-bit product in 32 iteration cycles. The block sits beside `alu` in the execute stage. While multiplying it owns the ALU operand and control lines; while idle it drives them to a neutral AND of zeros. It contains no adder of its own: every partial-sum addition goes through the ALU ADD code and uses the ALU `result` and `cout` outputs.

## Interface
- `WIDTH`, 32, operand width; must equal the ALU width.
- `CNT_W`, 5, iteration counter width; equals log2(WIDTH).

- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `start_i`  in  1  request; sampled only in IDLE or DONE.
- `mcand_i`  in  WIDTH  multiplicand, captured on an accepted start.
- `mplier_i`  in  WIDTH  multiplier, captured on an accepted start.
- `busy_o`  out  1  high in CALC.
- `done_o`  out  1  one-cycle pulse; product valid.
- `product_o`  out  2*WIDTH  product; held until the next accepted start.
- `alu_src1_o`  out  WIDTH  to ALU `src1`.
- `alu_src2_o`  out  WIDTH  to ALU `src2`.
- `alu_ctrl_o`  out  4  to ALU `ALU_control`.
- `alu_result_i`  in  WIDTH  from ALU `result`.
- `alu_cout_i`  in  1  from ALU `cout`.

## Operation
- Internal registers: `mcand_q[WIDTH]`, `hi_q[WIDTH]`, `lo_q[WIDTH]`, `cnt_q[CNT_W]`, and a 2-bit state.
- States: IDLE, CALC, DONE.
- IDLE → CALC on `start_i`. On that edge:
  - `mcand_q` ← `mcand_i`, `lo_q` ← `mplier_i`.
  - `hi_q` ← 0, `cnt_q` ← 0.
- While in CALC, the ALU is driven every cycle with:
  - `alu_ctrl_o` = 4'b0010 (ADD);
  - `alu_src1_o` = `hi_q`;
  - `alu_src2_o` = `lo_q[0]` ? `mcand_q` : 0.
- Each CALC edge performs one iteration:
  - `{hi_q, lo_q}` ← `{alu_cout_i, alu_result_i, lo_q[WIDTH-1:1]}`, a 65→64-bit right shift;
  - `cnt_q` increments.
- CALC → DONE on the edge where `cnt_q` = WIDTH-1. That is iteration 32; `cnt_q` wraps to 0.
- DONE → CALC on `start_i`, with the same capture as from IDLE. Otherwise DONE → IDLE.
- Outside CALC: `alu_ctrl_o` = 4'b0000 and both ALU operands are 0. The ALU output is ignored.
- `product_o` = `{hi_q, lo_q}` at all times outside CALC. During CALC it holds the last completed product. A separate registered copy is loaded on the CALC→DONE edge.
- `start_i` during CALC is ignored: no queueing, no restart.
- Operand values have no special cases. Zero operands still take 32 iterations.
- Arithmetic is unsigned only. `alu_cout_i` is the 33rd sum bit. Overflow from the ALU is unused.
- Reset, at any time including mid-CALC:
  - state → IDLE;
  - all registers and `product_o` → 0;
  - `busy_o` and `done_o` → 0;
  - ALU outputs → AND of zeros.
- Reset has priority over `start_i`.

## Timing
- A start accepted at edge t sets `busy_o` high from t to t+32.
- `done_o` is high for exactly the cycle after edge t+32.
- `product_o` is valid from that same cycle.
- Latency from accepted start to `done_o` is 33 cycles.
- Peak throughput is one product per 33 cycles, achieved by asserting `start_i` in the DONE cycle.
- The ALU path is combinational from registers through `alu` back to the registers, so the full ALU carry chain must close in one cycle.
- All outputs are registered or decoded from state only. Nothing is combinational from the inputs to `busy_o` or `done_o`.

## Structure
- Shared package `alu_pkg` holds:
  - the ALU control codes: AND 4'b0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100, NAND 1101;
  - the state enum `mul_state_t` {IDLE, CALC, DONE}.
- There is no sub-module. The ALU is instantiated by the parent (and the bench) and wired through the `alu_*` ports, with its `rst_n` tied to ~`rst_i`.

## Test plan
- 3 × 5, start at cycle 0 → `busy_o` high cycles 1–32; `done_o` at cycle 33; `product_o` = 64'h0000_0000_0000_000F.
- FFFF_FFFF × FFFF_FFFF → `product_o` = 64'hFFFF_FFFE_0000_0001; `alu_cout_i` exercised.
- 0 × 0x1234_5678 → `product_o` = 0 after the full 33 cycles; `alu_src2_o` stays 0 throughout CALC.
- Start 0x10000 × 0x10000, pulse `start_i` with 7 × 9 at cycle 10 → the second start is ignored; `product_o` = 64'h1_0000_0000 at cycle 33.
- Reset at iteration 10 → next cycle: IDLE, `product_o` = 0, `done_o` = 0, `alu_ctrl_o` = 0000. Then 7 × 6 → 42 after 33 cycles.
- Back-to-back: 2 × 3 then, with `start_i` asserted in the DONE cycle, 0x8000_0000 × 2 → 6 at cycle 33, then 64'h1_0000_0000 at cycle 66.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU control codes and the sequential multiplier state encoding.
// No logic; imported by the ALU consumers.
// No flow control.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_NAND = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier that borrows the shared ALU as its only adder.
// Latency: 33 cycles from accepted start to the done pulse; one product per 33 cycles.
// Backpressure: none; start is ignored while a product is being computed.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     mcand_i,
  input  logic [WIDTH-1:0]     mplier_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   product_o,
  output logic [WIDTH-1:0]     alu_src1_o,
  output logic [WIDTH-1:0]     alu_src2_o,
  output logic [3:0]           alu_ctrl_o,
  input  logic [WIDTH-1:0]     alu_result_i,
  input  logic                 alu_cout_i
);

  mul_state_t           state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, hi_q, lo_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   prod_q;
  logic [2*WIDTH-1:0]   shifted;
  logic                 calc;
  logic                 start_acc;
  logic                 last_iter;

  assign calc      = (state_q == CALC);
  assign start_acc = start_i && !calc;
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
  // Partial sum plus carry drops into hi, its LSB shifts into lo.
  assign shifted   = {alu_cout_i, alu_result_i, lo_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = CALC;
      CALC:    if (last_iter) state_d = DONE;
      DONE:    state_d = start_i ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alu_ctrl_o = ALU_AND;
    alu_src1_o = '0;
    alu_src2_o = '0;
    if (calc) begin
      alu_ctrl_o = ALU_ADD;
      alu_src1_o = hi_q;
      alu_src2_o = lo_q[0] ? mcand_q : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        mcand_q <= mcand_i;
        lo_q    <= mplier_i;
        hi_q    <= '0;
        cnt_q   <= '0;
      end else if (calc) begin
        {hi_q, lo_q} <= shifted;
        cnt_q        <= cnt_q + 1'b1;
        if (last_iter) prod_q <= shifted;
      end
    end
  end

  assign busy_o    = calc;
  assign done_o    = (state_q == DONE);
  // hi/lo are mid-shift during CALC, so expose the last finished product instead.
  assign product_o = calc ? prod_q : {hi_q, lo_q};

endmodule
